// File: rtl/ref_broadcast_sequencer.sv
// ref_broadcast_sequencer
// Walks every reference particle of one home cell and, for each reference,
// sweeps neighbour IDs 1, 2, ... until the external done checker reports that
// the sweep has run past the cell's particle count. The sweep freezes while the
// downstream filters signal back-pressure. A one-cycle cell_done pulse marks
// the end of the cell.
module ref_broadcast_sequencer #(
  parameter int ID_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ID_WIDTH-1:0] particle_count,
  input  logic                count_valid,
  input  logic                stall,
  input  logic                broadcast_done,
  output logic [ID_WIDTH-1:0] particle_id,
  output logic [ID_WIDTH-1:0] ref_id,
  output logic                rd_en,
  output logic                ref_load,
  output logic                cell_done,
  output logic                busy
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_COUNT = 2'd1;
  localparam logic [1:0] S_BROADCAST  = 2'd2;
  localparam logic [1:0] S_DONE       = 2'd3;

  // Both the neighbour and the reference sweeps restart at ID 1.
  localparam logic [ID_WIDTH-1:0] ID_ONE = {{(ID_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]          state_reg, state_next;
  logic [ID_WIDTH-1:0] count_reg, count_next;
  logic [ID_WIDTH-1:0] particle_id_reg, particle_id_next;
  logic [ID_WIDTH-1:0] ref_id_reg, ref_id_next;
  logic                ref_load_reg, ref_load_next;

  // Next-state and datapath decisions for the cell sweep.
  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    particle_id_next = particle_id_reg;
    ref_id_next      = ref_id_reg;
    ref_load_next    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_WAIT_COUNT;
        end
      end

      S_WAIT_COUNT: begin
        // The count is sampled exactly once per cell; later changes on
        // particle_count are ignored until the next start.
        if (count_valid) begin
          count_next = particle_count;
          if (particle_count == '0) begin
            state_next = S_DONE;
          end else begin
            state_next       = S_BROADCAST;
            particle_id_next = ID_ONE;
            ref_id_next      = ID_ONE;
            ref_load_next    = 1'b1;
          end
        end
      end

      S_BROADCAST: begin
        // Done wins over stall: the done cycle never issues a read, so there
        // is nothing to hold back.
        if (broadcast_done) begin
          if (ref_id_reg < count_reg) begin
            ref_id_next      = ref_id_reg + ID_ONE;
            particle_id_next = ID_ONE;
            ref_load_next    = 1'b1;
          end else begin
            state_next = S_DONE;
          end
        end else if (!stall) begin
          particle_id_next = particle_id_reg + ID_ONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any partially swept cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      count_reg       <= '0;
      particle_id_reg <= '0;
      ref_id_reg      <= '0;
      ref_load_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      particle_id_reg <= particle_id_next;
      ref_id_reg      <= ref_id_next;
      ref_load_reg    <= ref_load_next;
    end
  end

  assign particle_id = particle_id_reg;
  assign ref_id      = ref_id_reg;
  assign ref_load    = ref_load_reg;
  assign cell_done   = (state_reg == S_DONE);
  assign busy        = (state_reg != S_IDLE);
  // Read strobe follows the live stall/done inputs so a stalled ID is
  // reissued on the first free cycle without extra latency.
  assign rd_en       = (state_reg == S_BROADCAST) && !stall && !broadcast_done;

endmodule

// File: tb/tb_ref_broadcast_sequencer.sv
// Testbench for ref_broadcast_sequencer. The done checker is modelled as a
// continuous expression of the current cell count; expected per-cycle outputs
// come from a nested reference/neighbour loop walked against a stall plan.
module tb_ref_broadcast_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] particle_count;
  logic         count_valid;
  logic         stall;
  logic         broadcast_done;
  logic [W-1:0] particle_id;
  logic [W-1:0] ref_id;
  logic         rd_en;
  logic         ref_load;
  logic         cell_done;
  logic         busy;

  logic [W-1:0] cur_count;
  logic [W-1:0] last_pid;
  logic [W-1:0] last_rid;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] pid;
    logic [W-1:0] rid;
    logic         rd;
    logic         load;
  } exp_t;

  exp_t exp_q[$];
  bit   stall_plan[1024];

  always #5 clk = ~clk;

  // Behaviour of the external done checker.
  assign broadcast_done = (cur_count != '0) && (particle_id > cur_count);

  ref_broadcast_sequencer #(.ID_WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .particle_count (particle_count),
    .count_valid    (count_valid),
    .stall          (stall),
    .broadcast_done (broadcast_done),
    .particle_id    (particle_id),
    .ref_id         (ref_id),
    .rd_en          (rd_en),
    .ref_load       (ref_load),
    .cell_done      (cell_done),
    .busy           (busy)
  );

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] e_pid, input logic [W-1:0] e_rid,
                           input logic e_rd, input logic e_load, input logic e_done, input logic e_busy);
    chkw({tag, "_pid"}, particle_id, e_pid);
    chkw({tag, "_ref"}, ref_id, e_rid);
    chk1({tag, "_rd"}, rd_en, e_rd);
    chk1({tag, "_load"}, ref_load, e_load);
    chk1({tag, "_done"}, cell_done, e_done);
    chk1({tag, "_busy"}, busy, e_busy);
  endtask

  function automatic bit sp(input int k);
    return (k < 1024) ? stall_plan[k] : 1'b0;
  endfunction

  task automatic fill_stall(input int pct);
    for (int i = 0; i < 1024; i++) stall_plan[i] = ($urandom_range(0, 99) < pct);
  endtask

  // Expected BROADCAST trace: each reference sweeps 1..n, each ID waiting out
  // any stalled cycles before its read, then one done cycle at ID n+1.
  task automatic build_model(input int n);
    int   k;
    bit   first;
    exp_t e;
    exp_q.delete();
    k = 0;
    for (int r = 1; r <= n; r++) begin
      first = 1'b1;
      for (int p = 1; p <= n + 1; p++) begin
        if (p <= n) begin
          while (sp(k)) begin
            e.pid = p[W-1:0]; e.rid = r[W-1:0]; e.rd = 1'b0; e.load = first;
            exp_q.push_back(e); first = 1'b0; k++;
          end
          e.pid = p[W-1:0]; e.rid = r[W-1:0]; e.rd = 1'b1; e.load = first;
        end else begin
          e.pid = p[W-1:0]; e.rid = r[W-1:0]; e.rd = 1'b0; e.load = first;
        end
        exp_q.push_back(e); first = 1'b0; k++;
      end
    end
  endtask

  // One cell: start, wait_n idle cycles, count_valid, sweep, done, idle.
  // dup_at >= 0 pulses start again at that sweep cycle; abort_at >= 0 applies
  // reset right after that sweep cycle is checked.
  task automatic run_cell(input int n, input int wait_n, input logic [W-1:0] garb,
                          input int dup_at, input int abort_at);
    build_model(n);

    @(posedge clk); #1;
    start = 1'b1; count_valid = 1'b0; particle_count = garb; stall = 1'($urandom);
    @(negedge clk);
    chk1("start_busy", busy, 1'b0);
    chk1("start_rd", rd_en, 1'b0);

    for (int i = 0; i < wait_n; i++) begin
      @(posedge clk); #1;
      start = 1'b0; count_valid = 1'b0; particle_count = garb; stall = 1'($urandom);
      @(negedge clk);
      check_all("wait", last_pid, last_rid, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    @(posedge clk); #1;
    start = 1'b0; count_valid = 1'b1; particle_count = n[W-1:0]; cur_count = n[W-1:0];
    stall = 1'($urandom);
    @(negedge clk);
    check_all("cv", last_pid, last_rid, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); #1;
      count_valid = 1'b0; particle_count = W'($urandom);
      stall = sp(k); start = (k == dup_at);
      @(negedge clk);
      check_all("bc", exp_q[k].pid, exp_q[k].rid, exp_q[k].rd, exp_q[k].load, 1'b0, 1'b1);
      last_pid = exp_q[k].pid;
      last_rid = exp_q[k].rid;
      if (k == abort_at) begin
        #2; rst = 1'b1; #1;
        check_all("rst", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        last_pid = '0; last_rid = '0; cur_count = '0;
        return;
      end
    end

    @(posedge clk); #1;
    start = 1'b0; stall = 1'($urandom);
    @(negedge clk);
    check_all("done", last_pid, last_rid, 1'b0, 1'b0, 1'b1, 1'b1);

    @(posedge clk); #1;
    stall = 1'($urandom);
    @(negedge clk);
    check_all("idle", last_pid, last_rid, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("cell count=%0d wait=%0d sweep_cycles=%0d checks=%0d passed=%0d",
             n, wait_n, exp_q.size(), n_checks, n_pass);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count_valid = 1'b0; stall = 1'b0;
    particle_count = '0; cur_count = '0; last_pid = '0; last_rid = '0;
    fill_stall(0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all("post_reset", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Count 3, count_valid the cycle after start, no stall.
    fill_stall(0);
    run_cell(3, 0, 8'd7, -1, -1);

    // Count 2 with two stalled cycles while particle_id = 2 on reference 1.
    fill_stall(0);
    stall_plan[1] = 1'b1;
    stall_plan[2] = 1'b1;
    run_cell(2, 0, 8'd0, -1, -1);

    // Empty cell.
    fill_stall(0);
    run_cell(0, 0, 8'd5, -1, -1);

    // count_valid three cycles late while particle_count reads 0.
    fill_stall(0);
    run_cell(3, 3, 8'd0, -1, -1);

    // Second start mid-sweep is ignored.
    fill_stall(0);
    run_cell(2, 1, 8'd9, 2, -1);

    // Stall on the very first sweep cycle of a single-particle cell.
    fill_stall(0);
    stall_plan[0] = 1'b1;
    run_cell(1, 0, 8'd3, -1, -1);

    // Reset mid-sweep at particle_id = 2, ref_id = 1, then a fresh count-1 cell.
    fill_stall(0);
    run_cell(2, 0, 8'd0, -1, 1);
    fill_stall(0);
    run_cell(1, 0, 8'd0, -1, -1);

    // Randomized cells with random back-pressure.
    for (int c = 0; c < 8; c++) begin
      fill_stall(25);
      run_cell(int'($urandom_range(1, 10)), int'($urandom_range(0, 4)), W'($urandom),
               ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 20)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
